// File: rtl/kd_tree_ctrl_if.sv
`default_nettype none
// kd_tree_ctrl_if: start/status, center stream and root command/data port of kd_tree_ctrl.
interface kd_tree_ctrl_if #(
  parameter int COMMAND_SIZE = 5,
  parameter int DATA_SIZE    = 24,
  parameter int MAX_CENTERS  = 7
);
  localparam int CL_W = $clog2(MAX_CENTERS + 1);

  logic                    start;
  logic [DATA_SIZE-1:0]    center_data;
  logic                    center_valid;
  logic                    center_ready;
  logic [COMMAND_SIZE-1:0] command_to_root;
  logic [DATA_SIZE-1:0]    data_to_root;
  logic [COMMAND_SIZE-1:0] command_from_root;
  logic                    busy;
  logic                    done;
  logic                    error;
  logic [CL_W-1:0]         centers_loaded;
  logic [15:0]             sort_cycles;

  modport slave (
    input  start, center_data, center_valid, command_from_root,
    output center_ready, command_to_root, data_to_root,
           busy, done, error, centers_loaded, sort_cycles
  );

  modport master (
    output start, center_data, center_valid, command_from_root,
    input  center_ready, command_to_root, data_to_root,
           busy, done, error, centers_loaded, sort_cycles
  );
endinterface
`default_nettype wire

// File: rtl/kd_tree_ctrl.sv
`default_nettype none
// ============================================================================
// kd_tree_ctrl: sequences kd-tree root through reset, center fill and sort.
// Optional sort cycle counter: define KD_TREE_CTRL_CYCLE_COUNT_EN.
// Revision: 1.0
// ============================================================================
module kd_tree_ctrl #(
  parameter int COMMAND_SIZE   = 5,
  parameter int DATA_SIZE      = 24,
  parameter int MAX_CENTERS    = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           clk,
  input  logic           reset,
  kd_tree_ctrl_if.slave  bus
);
  localparam int CL_W  = $clog2(MAX_CENTERS + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [COMMAND_SIZE-1:0] CMD_NOP       = COMMAND_SIZE'('h00);
  localparam logic [COMMAND_SIZE-1:0] CMD_FILL      = COMMAND_SIZE'('h01);
  localparam logic [COMMAND_SIZE-1:0] CMD_FILL_DONE = COMMAND_SIZE'('h05);
  localparam logic [COMMAND_SIZE-1:0] CMD_SORT      = COMMAND_SIZE'('h14);
  localparam logic [COMMAND_SIZE-1:0] CMD_SORT_DONE = COMMAND_SIZE'('h15);
  localparam logic [COMMAND_SIZE-1:0] CMD_RST       = COMMAND_SIZE'('h1f);
  localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE  = COMMAND_SIZE'('h1e);
  localparam logic [CL_W-1:0]         LOAD_MAX      = CL_W'(MAX_CENTERS);
  localparam logic [TMO_W-1:0]        TMO_LAST      = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST_TREE, S_FILL, S_SORT_KICK, S_SORT_WAIT, S_DONE, S_ERR
  } state_t;

  state_t                  r_state, w_state;
  logic [COMMAND_SIZE-1:0] r_cmd, w_cmd;
  logic [DATA_SIZE-1:0]    r_data, w_data;
  logic                    r_busy, w_busy;
  logic                    r_done, w_done;
  logic                    r_error, w_error;
  logic [CL_W-1:0]         r_loaded, w_loaded;
  logic [TMO_W-1:0]        r_tmo, w_tmo;
  logic                    w_ready;
  logic                    w_tmo_hit;

  // fill_done from the root beats the cap and blocks acceptance in the same cycle
  assign w_ready   = (r_state == S_FILL) && (bus.command_from_root != CMD_FILL_DONE)
                     && (r_loaded != LOAD_MAX);
  assign w_tmo_hit = (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_cmd    <= CMD_NOP;
      r_data   <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_error  <= 1'b0;
      r_loaded <= '0;
      r_tmo    <= '0;
    end else begin
      r_state  <= w_state;
      r_cmd    <= w_cmd;
      r_data   <= w_data;
      r_busy   <= w_busy;
      r_done   <= w_done;
      r_error  <= w_error;
      r_loaded <= w_loaded;
      r_tmo    <= w_tmo;
    end
  end

  always_comb begin
    w_state  = r_state;
    w_cmd    = CMD_NOP;
    w_data   = r_data;
    w_busy   = (r_state != S_IDLE);
    w_done   = (r_state == S_DONE);
    w_error  = r_error;
    w_loaded = r_loaded;
    w_tmo    = r_tmo;
    case (r_state)
      S_IDLE: begin
        w_data = '0;
        if (bus.start && !r_busy) begin
          w_error  = 1'b0;
          w_loaded = '0;
          w_tmo    = '0;
          w_state  = S_RST_TREE;
        end
      end
      S_RST_TREE: begin
        w_cmd  = CMD_RST;
        w_data = '0;
        if (bus.command_from_root == CMD_RST_DONE) begin
          w_state = S_FILL;
          w_tmo   = '0;
        end else if (w_tmo_hit) begin
          w_cmd   = CMD_NOP;
          w_error = 1'b1;
          w_state = S_ERR;
          w_tmo   = '0;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_FILL: begin
        if (!w_ready) begin
          w_state = S_SORT_KICK;
          w_tmo   = '0;
        end else if (bus.center_valid) begin
          w_cmd    = CMD_FILL;
          w_data   = bus.center_data;
          w_loaded = r_loaded + 1'b1;
          w_tmo    = '0;
        end else if (w_tmo_hit) begin
          w_error = 1'b1;
          w_state = S_ERR;
          w_tmo   = '0;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_SORT_KICK: begin
        w_cmd   = CMD_SORT;
        w_data  = '0;
        w_state = S_SORT_WAIT;
        w_tmo   = '0;
      end
      S_SORT_WAIT: begin
        w_data = '0;
        if (bus.command_from_root == CMD_SORT_DONE) begin
          w_state = S_DONE;
          w_tmo   = '0;
        end else if (w_tmo_hit) begin
          w_error = 1'b1;
          w_state = S_ERR;
          w_tmo   = '0;
        end else begin
          w_tmo = r_tmo + 1'b1;
        end
      end
      S_DONE:  w_state = S_IDLE;
      S_ERR: begin
        w_data  = '0;
        w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

`ifdef KD_TREE_CTRL_CYCLE_COUNT_EN
  logic [15:0] r_sort_cycles;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sort_cycles <= '0;
    end else if (r_state == S_SORT_KICK) begin
      r_sort_cycles <= '0;
    end else if ((r_state == S_SORT_WAIT) && (r_sort_cycles != 16'hFFFF)) begin
      r_sort_cycles <= r_sort_cycles + 16'd1;
    end
  end

  assign bus.sort_cycles = r_sort_cycles;
`else
  assign bus.sort_cycles = 16'd0;
`endif

  assign bus.center_ready    = w_ready;
  assign bus.command_to_root = r_cmd;
  assign bus.data_to_root    = r_data;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.error           = r_error;
  assign bus.centers_loaded  = r_loaded;
endmodule
`default_nettype wire

// File: tb/tb_kd_tree_ctrl.sv
`default_nettype none
// tb_kd_tree_ctrl: directed checks of reset flow, fill, cap, sort, timeout and async reset.
module tb_kd_tree_ctrl;
  localparam int CS = 5;
  localparam int DS = 24;
  localparam int MC = 7;
  localparam logic [4:0] NOP = 5'h00, FILL = 5'h01, FDONE = 5'h05, KICK = 5'h14;
  localparam logic [4:0] SDONE = 5'h15, RST = 5'h1f, RDONE = 5'h1e;
`ifdef KD_TREE_CTRL_CYCLE_COUNT_EN
  localparam logic [15:0] EXP_SORT = 16'd40;
`else
  localparam logic [15:0] EXP_SORT = 16'd0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  kd_tree_ctrl_if #(.COMMAND_SIZE(CS), .DATA_SIZE(DS), .MAX_CENTERS(MC)) bus ();
  kd_tree_ctrl_if #(.COMMAND_SIZE(CS), .DATA_SIZE(DS), .MAX_CENTERS(MC)) bus_to ();

  kd_tree_ctrl #(.COMMAND_SIZE(CS), .DATA_SIZE(DS), .MAX_CENTERS(MC), .TIMEOUT_CYCLES(1024))
    u_dut (.clk(clk), .reset(reset), .bus(bus));
  kd_tree_ctrl #(.COMMAND_SIZE(CS), .DATA_SIZE(DS), .MAX_CENTERS(MC), .TIMEOUT_CYCLES(16))
    u_dut_to (.clk(clk), .reset(reset), .bus(bus_to));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start_pulse();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Root model: answer rst_done once rst has been seen for three cycles.
  task automatic rst_phase(output int n_rst);
    n_rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.command_to_root == RST) n_rst++;
      bus.command_from_root = (n_rst == 3) ? RDONE : NOP;
    end
  endtask

  logic [23:0] cen [5];
  int          n_rst, idx, beats, kicks, kick_bad;
  logic [23:0] last_data;
  logic        will, ready_after_cap;

  initial begin
    cen = '{24'h112233, 24'h223344, 24'h334455, 24'h445566, 24'h556677};
    bus.start = 0; bus.center_valid = 0; bus.center_data = '0; bus.command_from_root = NOP;
    bus_to.start = 0; bus_to.center_valid = 0; bus_to.center_data = '0;
    bus_to.command_from_root = NOP;

    #2;
    check("rst_cmd", bus.command_to_root, NOP);
    check("rst_data", bus.data_to_root, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_error", bus.error, 0);
    check("rst_loaded", bus.centers_loaded, 0);
    check("rst_sortcyc", bus.sort_cycles, 0);
    check("rst_ready", bus.center_ready, 0);
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);

    // reset flow
    start_pulse();
    check("busy_at_start_edge", bus.busy, 0);
    rst_phase(n_rst);
    check("rst_cycles", n_rst, 4);
    check("fill_idle_cmd", bus.command_to_root, NOP);
    check("busy_in_fill", bus.busy, 1);

    // fill with gaps
    for (int k = 0; k < 5; k++) begin
      bus.center_valid = 1'b1;
      bus.center_data  = cen[k];
      check("fill_ready", bus.center_ready, 1);
      @(negedge clk);
      check("fill_cmd", bus.command_to_root, FILL);
      check("fill_data", bus.data_to_root, cen[k]);
      bus.center_valid = 1'b0;
      bus.center_data  = '0;
      if (k == 4) bus.command_from_root = FDONE;
      @(negedge clk);
      if (k < 4) begin
        check("gap_cmd", bus.command_to_root, NOP);
        check("gap_data_hold", bus.data_to_root, cen[k]);
      end
    end
    check("kick_state_ready", bus.center_ready, 0);
    bus.command_from_root = NOP;
    check("loaded_5", bus.centers_loaded, 5);
    @(negedge clk);
    check("kick_cmd", bus.command_to_root, KICK);
    check("kick_data", bus.data_to_root, 0);

    // sort completion 40 cycles after kick
    repeat (39) @(negedge clk);
    check("sort_wait_cmd", bus.command_to_root, NOP);
    bus.command_from_root = SDONE;
    @(negedge clk);
    bus.command_from_root = NOP;
    check("done_not_yet", bus.done, 0);
    @(negedge clk);
    check("done_pulse", bus.done, 1);
    check("busy_with_done", bus.busy, 1);
    @(negedge clk);
    check("done_cleared", bus.done, 0);
    check("busy_fell", bus.busy, 0);
    check("sort_cycles", bus.sort_cycles, EXP_SORT);
    check("no_error", bus.error, 0);

    // fill cap: 8 offered, 7 accepted
    start_pulse();
    rst_phase(n_rst);
    idx = 0; beats = 0; kicks = 0; kick_bad = 0; last_data = '0; ready_after_cap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (idx < 8) begin
        bus.center_valid = 1'b1;
        bus.center_data  = 24'hA00000 + 24'(idx);
      end else begin
        bus.center_valid = 1'b0;
      end
      if (idx == 7) ready_after_cap = ready_after_cap | bus.center_ready;
      will = bus.center_ready & bus.center_valid;
      @(negedge clk);
      if (will) idx++;
      if (bus.command_to_root == FILL) begin
        beats++;
        last_data = bus.data_to_root;
      end
      if (bus.command_to_root == KICK) begin
        kicks++;
        if (bus.data_to_root != 0) kick_bad++;
      end
    end
    bus.center_valid = 1'b0;
    check("cap_accepted", idx, 7);
    check("cap_beats", beats, 7);
    check("cap_loaded", bus.centers_loaded, 7);
    check("cap_last_data", last_data, 24'hA00006);
    check("cap_ready_low", ready_after_cap, 0);
    check("cap_kicks", kicks, 1);
    check("cap_kick_data", kick_bad, 0);

    // asynchronous reset in SORT_WAIT
    #3 reset = 1'b0;
    #1;
    check("areset_busy", bus.busy, 0);
    check("areset_loaded", bus.centers_loaded, 0);
    check("areset_cmd", bus.command_to_root, NOP);
    check("areset_sortcyc", bus.sort_cycles, 0);
    @(negedge clk) reset = 1'b1;

    // start while busy is ignored
    start_pulse();
    rst_phase(n_rst);
    check("rerun_rst_cycles", n_rst, 4);
    bus.center_valid = 1'b1;
    bus.center_data  = 24'h0A0B0C;
    repeat (2) @(negedge clk);
    bus.center_valid = 1'b0;
    check("busy_loaded_2", bus.centers_loaded, 2);
    start_pulse();
    check("ignored_start_loaded", bus.centers_loaded, 2);
    check("ignored_start_busy", bus.busy, 1);
    @(negedge clk);
    check("ignored_start_cmd", bus.command_to_root, NOP);

    // timeout, second instance with TIMEOUT_CYCLES=16
    @(negedge clk) bus_to.start = 1'b1;
    @(negedge clk) bus_to.start = 1'b0;
    repeat (15) @(negedge clk);
    check("to_error_early", bus_to.error, 0);
    check("to_busy", bus_to.busy, 1);
    @(negedge clk);
    check("to_error_set", bus_to.error, 1);
    check("to_cmd_nop", bus_to.command_to_root, NOP);
    repeat (3) @(negedge clk);
    check("to_idle_busy", bus_to.busy, 0);
    check("to_error_sticky", bus_to.error, 1);
    @(negedge clk) bus_to.start = 1'b1;
    @(negedge clk) bus_to.start = 1'b0;
    check("to_error_cleared", bus_to.error, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/kd_tree_ctrl.md
# kd_tree_ctrl

Sequencing controller that sits directly upstream of the kd-tree root node and drives its top-side command/data port. On `start`, it runs the tree through three phases: reset, center fill from a valid/ready center stream, and sort. It then waits for the root to report `sort_done` and reports completion, timeout or error to the surrounding K-means datapath.

## Interface
Parameters:
- `COMMAND_SIZE`, 5, width of node command bus.
- `DATA_SIZE`, 24, width of node data bus (packed RGB center).
- `MAX_CENTERS`, 7, centers accepted before fill is forced complete (node count of tree).
- `TIMEOUT_CYCLES`, 1024, max cycles spent waiting for any root acknowledgement.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to begin a build; ignored unless `busy`=0.
- `center_data`  in  DATA_SIZE  next center from the center source.
- `center_valid`  in  1  `center_data` is valid.
- `center_ready`  out  1  controller accepts `center_data` this cycle.
- `command_to_root`  out  COMMAND_SIZE  drives root `command_from_top`.
- `data_to_root`  out  DATA_SIZE  drives root `data_from_top`.
- `command_from_root`  in  COMMAND_SIZE  root `command_to_top`.
- `busy`  out  1  high from the cycle after accepted `start` until return to IDLE.
- `done`  out  1  one-cycle pulse on successful sort completion.
- `error`  out  1  sticky timeout flag, cleared by next accepted `start`.
- `centers_loaded`  out  $clog2(MAX_CENTERS+1)  count of centers sent in last/current fill.
- `sort_cycles`  out  16  cycles from sort kick to `sort_done` (see Configuration).

## Operation
- Command codes (hex): nop 00, center_fill 01, center_fill_done 05, start_sorting_as_root 14, sort_done 15, rst 1f, rst_done 1e.
- States: IDLE, RST_TREE, FILL, SORT_KICK, SORT_WAIT, DONE, ERR.
- IDLE: `command_to_root`=nop, `data_to_root`=0. On `start`, clear `error`, `centers_loaded` and the timeout counter, then go to RST_TREE.
- RST_TREE: drive rst each cycle. On `command_from_root`==rst_done, go to FILL.
- FILL: `center_ready`=1 unless `command_from_root`==center_fill_done or `centers_loaded`==MAX_CENTERS.
  - On `center_valid`&`center_ready`: drive center_fill with `center_data` and increment `centers_loaded`.
  - With no valid center: drive nop and hold `data_to_root`.
  - On center_fill_done, or when `centers_loaded`==MAX_CENTERS, go to SORT_KICK. If both occur in the same cycle, center_fill_done wins; no center is accepted in that cycle.
- SORT_KICK: drive start_sorting_as_root with data 0 for exactly one cycle, then go to SORT_WAIT.
- SORT_WAIT: drive nop. On sort_done, go to DONE.
- DONE: pulse `done` for one cycle, then go to IDLE.
- Timeout: a counter runs in RST_TREE, FILL (only while no center is accepted) and SORT_WAIT. It resets on every state change and on every accepted center. On reaching TIMEOUT_CYCLES, set `error`, drive nop, and go to ERR.
- ERR: drive nop and hold `error`=1. Go to IDLE the next cycle; `error` stays set until the next accepted `start`.
- `start` while `busy`=1 is ignored.
- Unknown codes on `command_from_root` are treated as "not yet".

## Timing
- All outputs are registered except `center_ready`, which is a combinational decode of state, `centers_loaded` and `command_from_root`.
- Reset values: state IDLE, `command_to_root`=nop, `data_to_root`=0, `busy`=0, `done`=0, `error`=0, `centers_loaded`=0, `sort_cycles`=0.
- An asserted reset mid-operation aborts immediately. The tree is not notified; the next `start` re-issues rst.
- `start` at edge N: rst appears on `command_to_root` after edge N+1, and `busy`=1 after edge N+1.
- An acknowledgement sampled at edge N changes `command_to_root` after edge N+1.
- Accepted center at edge N: `data_to_root`/center_fill are valid after edge N, so the root samples them at edge N+1.
- `done` is asserted the cycle after sort_done is sampled; `busy` falls with `done`.

## Configuration
- `KD_TREE_CTRL_CYCLE_COUNT_EN` defined: `sort_cycles` clears in SORT_KICK and increments each SORT_WAIT cycle, saturating at 16'hFFFF. It holds its value after DONE or ERR until the next SORT_KICK.
- `KD_TREE_CTRL_CYCLE_COUNT_EN` undefined: the counter is not built and `sort_cycles` is tied to 0.

## Test plan
- Reset flow: release reset, pulse `start`; root model answers rst_done 3 cycles later → rst driven for exactly 4 cycles, then FILL.
- Fill with gaps: 5 centers 0x112233..0x556677 with one invalid cycle between each; root answers center_fill_done after 5th → 5 center_fill beats in order, nop on gap cycles, `centers_loaded`=5.
- Fill cap: 8 valid centers offered, root never sends fill_done → exactly 7 accepted, `center_ready`=0 afterwards, one start_sorting_as_root with data 0.
- Sort completion: root returns sort_done 40 cycles after kick → `done` pulses once, `busy` falls, `sort_cycles`=40 with macro and 0 without.
- Timeout: root never answers rst_done, TIMEOUT_CYCLES=16 → `error`=1 after 16 waiting cycles, return to IDLE. Next `start` clears `error`.
- Async reset mid-SORT_WAIT: assert reset asynchronously → outputs go to reset values immediately, `start` during the subsequent `busy`=1 window is ignored.
